// File: rtl/serial_tx_pkg.sv
// Shared constants and state encoding for the serial frame transmitter.
package serial_tx_pkg;

    localparam int SERIAL_DATA_LENGTH = 22;
    localparam int SERIAL_ADDR_WIDTH  = 5;
    localparam int CHECKSUM_WIDTH     = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_STATUS   = 3'd2,
        ST_DATA     = 3'd3,
        ST_CHECKSUM = 3'd4
    } tx_state_e;

endpackage

// File: rtl/serial_checksum_accumulator.sv
// Running modulo-256 sum of every byte handed to the UART during one frame.
module serial_checksum_accumulator
    import serial_tx_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clear_i,
    input  logic                      add_i,
    input  logic [CHECKSUM_WIDTH-1:0] byte_i,
    output logic [CHECKSUM_WIDTH-1:0] sum_o
);

    logic [CHECKSUM_WIDTH-1:0] r_sum;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sum <= '0;
        end else if (clear_i) begin
            r_sum <= '0;
        end else if (add_i) begin
            r_sum <= r_sum + byte_i;
        end
    end

    assign sum_o = r_sum;

endmodule

// File: rtl/serial_frame_transmitter.sv
// Streams header, status, DATA_LENGTH RAM bytes and an optional checksum to a byte UART.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | waiting for transmit_i
// ST_HEADER   | sending latched header byte
// ST_STATUS   | sending latched status byte
// ST_DATA     | sending ram_i, address advances per byte
// ST_CHECKSUM | sending sum of all previous frame bytes
module serial_frame_transmitter
    import serial_tx_pkg::*;
#(
    parameter int DATA_LENGTH = SERIAL_DATA_LENGTH,
    parameter int ADDR_WIDTH  = SERIAL_ADDR_WIDTH,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  transmit_i,
    input  logic [7:0]            header_byte_i,
    input  logic [7:0]            status_byte_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [7:0]            ram_i,
    output logic [7:0]            tx_byte_o,
    output logic                  new_tx_data_o,
    input  logic                  tx_busy_i,
    output logic                  busy_o,
    output logic                  done_o
);

    // Count is one bit wider than the address so a full-RAM frame can be counted.
    localparam int             CW  = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  LEN = CW'(DATA_LENGTH);
    localparam tx_state_e AFTER_DATA   = CHECKSUM_EN ? ST_CHECKSUM : ST_IDLE;
    localparam tx_state_e AFTER_STATUS = (DATA_LENGTH == 0) ? AFTER_DATA : ST_DATA;

    tx_state_e             r_state;
    logic                  r_holdoff;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_header;
    logic [7:0]            r_status;
    logic [7:0]            r_tx_byte;
    logic                  r_new_tx;
    logic                  r_busy;
    logic                  r_done;

    tx_state_e             w_next;
    logic [7:0]            w_byte;
    logic [7:0]            w_sum;
    logic [CW-1:0]         w_count_inc;
    logic                  w_accept;
    logic                  w_send;

    assign w_accept    = (r_state == ST_IDLE) && transmit_i;
    assign w_send      = (r_state != ST_IDLE) && !r_holdoff && !tx_busy_i;
    assign w_count_inc = r_count + CW'(1);

    always_comb begin
        w_byte = r_header;
        w_next = r_state;
        case (r_state)
            ST_HEADER: begin
                w_byte = r_header;
                w_next = ST_STATUS;
            end
            ST_STATUS: begin
                w_byte = r_status;
                w_next = AFTER_STATUS;
            end
            ST_DATA: begin
                w_byte = ram_i;
                w_next = (w_count_inc == LEN) ? AFTER_DATA : ST_DATA;
            end
            ST_CHECKSUM: begin
                w_byte = w_sum;
                w_next = ST_IDLE;
            end
            default: begin
                w_byte = r_header;
                w_next = r_state;
            end
        endcase
    end

    serial_checksum_accumulator u_checksum (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (w_accept),
        .add_i   (w_send),
        .byte_i  (w_byte),
        .sum_o   (w_sum)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_holdoff <= 1'b0;
            r_count   <= '0;
            r_addr    <= '0;
            r_header  <= '0;
            r_status  <= '0;
            r_tx_byte <= '0;
            r_new_tx  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_new_tx  <= 1'b0;
            r_done    <= 1'b0;
            r_holdoff <= 1'b0;
            if (w_accept) begin
                r_header <= header_byte_i;
                r_status <= status_byte_i;
                r_addr   <= '0;
                r_count  <= '0;
                r_busy   <= 1'b1;
                r_state  <= ST_HEADER;
            end else if (w_send) begin
                // Holdoff masks a UART busy flag that rises a cycle after the strobe.
                r_tx_byte <= w_byte;
                r_new_tx  <= 1'b1;
                r_holdoff <= 1'b1;
                r_state   <= w_next;
                if (r_state == ST_DATA) begin
                    r_addr  <= r_addr + ADDR_WIDTH'(1);
                    r_count <= w_count_inc;
                end
                if (w_next == ST_IDLE) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign ram_addr_o    = r_addr;
    assign tx_byte_o     = r_tx_byte;
    assign new_tx_data_o = r_new_tx;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Scoreboard bench: expected frame bytes are queued at request time and popped on each strobe.
module tb_serial_frame_transmitter;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       transmit1, transmit2;
    logic [7:0] header, status;
    logic       tx_busy1, tx_busy2;
    logic [7:0] ram1, ram2;
    logic [4:0] addr1, addr2;
    logic [7:0] tx_byte1, tx_byte2;
    logic       new1, new2, busy1, busy2, done1, done2;

    logic [7:0] mem [32];
    exp_t       q1[$];
    exp_t       q2[$];
    int         strobe_cyc[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         strobes1 = 0;
    int         strobes2 = 0;
    int         busy_mode = 0;

    serial_frame_transmitter #(.DATA_LENGTH(4), .ADDR_WIDTH(5), .CHECKSUM_EN(1'b1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .transmit_i(transmit1),
        .header_byte_i(header), .status_byte_i(status),
        .ram_addr_o(addr1), .ram_i(ram1), .tx_byte_o(tx_byte1),
        .new_tx_data_o(new1), .tx_busy_i(tx_busy1), .busy_o(busy1), .done_o(done1)
    );

    serial_frame_transmitter #(.DATA_LENGTH(0), .ADDR_WIDTH(5), .CHECKSUM_EN(1'b0)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .transmit_i(transmit2),
        .header_byte_i(header), .status_byte_i(status),
        .ram_addr_o(addr2), .ram_i(ram2), .tx_byte_o(tx_byte2),
        .new_tx_data_o(new2), .tx_busy_i(tx_busy2), .busy_o(busy2), .done_o(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous RAM, one cycle read latency.
    always @(posedge clk) ram1 <= mem[addr1];

    initial begin
        watchdog();
    end

    task automatic watchdog();
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    endtask

    // UART busy model: mode 1 = busy right after each strobe for 10 cycles,
    // mode 2 = busy rises one cycle late and stays up for 5 cycles.
    initial begin
        int busy_cnt;
        bit late_pending;
        busy_cnt     = 0;
        late_pending = 0;
        tx_busy1     = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_mode == 1) begin
                if (new1 === 1'b1) busy_cnt = 10;
            end else if (busy_mode == 2) begin
                if (late_pending) begin
                    busy_cnt     = 5;
                    late_pending = 0;
                end
                if (new1 === 1'b1) late_pending = 1;
            end else begin
                busy_cnt     = 0;
                late_pending = 0;
            end
            if (busy_cnt > 0) begin
                tx_busy1 = 1'b1;
                busy_cnt--;
            end else begin
                tx_busy1 = 1'b0;
            end
        end
    end

    task automatic check_strobe(input int which, input logic [7:0] b, input logic dn, input logic bz);
        exp_t e;
        tests++;
        if ((which == 1 && q1.size() == 0) || (which == 2 && q2.size() == 0)) begin
            fails++;
            $display("FAIL unexpected_strobe dut%0d: got byte %h, expected no strobe", which, b);
            return;
        end
        e = (which == 1) ? q1.pop_front() : q2.pop_front();
        if (b !== e.b || dn !== e.last || bz !== !e.last) begin
            fails++;
            $display("FAIL strobe dut%0d: got byte=%h done=%b busy=%b, expected byte=%h done=%b busy=%b",
                     which, b, dn, bz, e.b, e.last, !e.last);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (new1 === 1'b1) begin
            strobes1++;
            strobe_cyc.push_back(cyc);
            check_strobe(1, tx_byte1, done1, busy1);
        end else if (done1 !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL done_without_strobe dut1: got done=%b, expected 0", done1);
        end
        if (new2 === 1'b1) begin
            strobes2++;
            check_strobe(2, tx_byte2, done2, busy2);
        end else if (done2 !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL done_without_strobe dut2: got done=%b, expected 0", done2);
        end
    end

    task automatic push_frame(input int which, input logic [7:0] h, input logic [7:0] s,
                              input int dl, input bit ck);
        logic [7:0] sum;
        sum = h + s;
        if (which == 1) q1.push_back('{h, 1'b0}); else q2.push_back('{h, 1'b0});
        if (which == 1) q1.push_back('{s, (dl == 0 && !ck)});
        else            q2.push_back('{s, (dl == 0 && !ck)});
        for (int i = 0; i < dl; i++) begin
            sum = sum + mem[i];
            if (which == 1) q1.push_back('{mem[i], (i == dl - 1 && !ck)});
            else            q2.push_back('{mem[i], (i == dl - 1 && !ck)});
        end
        if (ck) begin
            if (which == 1) q1.push_back('{sum, 1'b1}); else q2.push_back('{sum, 1'b1});
        end
    endtask

    task automatic start_frame1(input logic [7:0] h, input logic [7:0] s, output int e0);
        @(negedge clk);
        header    = h;
        status    = s;
        transmit1 = 1'b1;
        push_frame(1, h, s, 4, 1'b1);
        @(posedge clk);
        #1 e0 = cyc;
        @(negedge clk);
        transmit1 = 1'b0;
    endtask

    task automatic wait_idle1(input int budget);
        int n;
        n = 0;
        while ((q1.size() != 0 || busy1 !== 1'b0) && n < budget) begin
            @(negedge clk);
            #1 n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL frame_timeout dut1: %0d bytes still pending after %0d cycles, expected 0", q1.size(), budget);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic check_count(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if ({new1, done1, busy1, tx_byte1, addr1, new2, done2, busy2} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got new=%b done=%b busy=%b byte=%h addr=%h, expected all 0",
                     new1, done1, busy1, tx_byte1, addr1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int e0;
        strobe_cyc.delete();
        start_frame1(8'hA5, 8'h3C, e0);
        tests++;
        if (busy1 !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_accept: got %b, expected 1", busy1);
        end
        wait_idle1(100);
        check_count("basic_strobe_count", strobe_cyc.size(), 7);
        for (int i = 0; i < strobe_cyc.size() && i < 7; i++)
            check_count($sformatf("basic_strobe_edge_%0d", i), strobe_cyc[i] - e0, 2 * i + 1);
        check_count("basic_busy_after_frame", int'(busy1), 0);
    endtask

    task automatic test_busy_hold();
        int e0;
        strobe_cyc.delete();
        busy_mode = 1;
        start_frame1(8'hA5, 8'h3C, e0);
        wait_idle1(400);
        check_count("busy_hold_strobe_count", strobe_cyc.size(), 7);
        for (int i = 1; i < strobe_cyc.size(); i++)
            check_count($sformatf("busy_hold_spacing_%0d", i), strobe_cyc[i] - strobe_cyc[i-1], 11);
        busy_mode = 0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_late_busy();
        int e0;
        strobe_cyc.delete();
        busy_mode = 2;
        start_frame1(8'hA5, 8'h3C, e0);
        wait_idle1(300);
        check_count("late_busy_strobe_count", strobe_cyc.size(), 7);
        busy_mode = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_no_data();
        int n;
        strobes2 = 0;
        @(negedge clk);
        header    = 8'hA5;
        status    = 8'h3C;
        transmit2 = 1'b1;
        push_frame(2, 8'hA5, 8'h3C, 0, 1'b0);
        @(negedge clk);
        transmit2 = 1'b0;
        n = 0;
        while ((q2.size() != 0 || busy2 !== 1'b0) && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        check_count("no_data_timeout_cycles_ok", int'(n < 50), 1);
        repeat (10) @(negedge clk);
        check_count("no_data_strobe_count", strobes2, 2);
    endtask

    task automatic test_reset_mid();
        int e0, n;
        strobes1 = 0;
        start_frame1(8'hA5, 8'h3C, e0);
        n = 0;
        while (strobes1 < 3 && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        check_count("reset_mid_reached_third", strobes1, 3);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({new1, done1, busy1, tx_byte1, addr1} !== '0) begin
            fails++;
            $display("FAIL reset_mid_async: got new=%b done=%b busy=%b byte=%h addr=%h, expected all 0",
                     new1, done1, busy1, tx_byte1, addr1);
        end
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_count("reset_mid_no_more_strobes", strobes1, 3);
        strobe_cyc.delete();
        start_frame1(8'hA5, 8'h3C, e0);
        wait_idle1(100);
        check_count("reset_mid_restart_strobes", strobe_cyc.size(), 7);
    endtask

    task automatic test_ignore();
        int e0;
        strobe_cyc.delete();
        start_frame1(8'hA5, 8'h3C, e0);
        repeat (2) @(negedge clk);
        transmit1 = 1'b1;
        @(negedge clk);
        transmit1 = 1'b0;
        repeat (4) @(negedge clk);
        transmit1 = 1'b1;
        @(negedge clk);
        transmit1 = 1'b0;
        wait_idle1(100);
        check_count("ignore_strobe_count", strobe_cyc.size(), 7);
    endtask

    task automatic test_back_to_back();
        int e0, dc, n;
        strobe_cyc.delete();
        @(negedge clk);
        header    = 8'hA5;
        status    = 8'h3C;
        transmit1 = 1'b1;
        push_frame(1, 8'hA5, 8'h3C, 4, 1'b1);
        @(posedge clk);
        #1 e0 = cyc;
        @(negedge clk);
        header = 8'h5A;
        push_frame(1, 8'h5A, 8'h3C, 4, 1'b1);
        n = 0;
        while (done1 !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        dc = cyc;
        check_count("b2b_first_done_edge", dc - e0, 13);
        @(posedge clk);
        #1;
        check_count("b2b_second_accept_busy", int'(busy1), 1);
        transmit1 = 1'b0;
        wait_idle1(100);
        check_count("b2b_strobe_count", strobe_cyc.size(), 14);
        if (strobe_cyc.size() > 7)
            check_count("b2b_second_header_edge", strobe_cyc[7] - dc, 2);
    endtask

    initial begin
        rst_n     = 1'b1;
        transmit1 = 1'b0;
        transmit2 = 1'b0;
        header    = 8'h00;
        status    = 8'h00;
        tx_busy2  = 1'b0;
        ram2      = 8'h00;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);

        test_reset();
        test_basic();
        test_busy_hold();
        test_late_busy();
        test_no_data();
        test_reset_mid();
        test_ignore();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
